instr_window_buffer: RTL and testbench
======================================

INSTR_WINDOW_BUFFER -- requirements
Module: instr_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the byte-lane width.
REQ-002 SHALL have parameter DEPTH, default 256, giving the storage entries; power of two, at least 2*max(WR_WIN,RD_WIN).
REQ-003 SHALL have parameter ADDR_WIDTH, default log2(DEPTH), giving the pointer width.
REQ-004 SHALL have parameter WR_WIN, default 4, giving the maximum lanes per write; power of two, at least 2.
REQ-005 SHALL have parameter RD_WIN, default 8, giving the lanes per read window; power of two, at least 2.
REQ-006 SHALL have ports, one per line:
- clk  in  1  clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  discard all contents.
- wr_vld  in  1  write request.
- wr_cnt_m1  in  log2(WR_WIN)  lanes to write minus one.
- wr_data  in  WR_WIN*DATA_WIDTH  lane 0 in the LSBs.
- wr_rdy  out  1  write can be accepted.
- rd_req  in  1  read-window request.
- rd_data  out  RD_WIN*DATA_WIDTH  window starting at the read pointer, lane 0 in the LSBs.
- rd_vld  out  1  rd_data valid.
- rd_avail  out  log2(RD_WIN)+1  valid lanes in rd_data.
- shift_vld  in  1  consume request.
- shift_cnt_m1  in  log2(RD_WIN)  lanes to consume minus one.
- shift_err  out  1  consume rejected.
- level  out  ADDR_WIDTH+1  occupied entries.
- empty  out  1  level==0; marks instruction stream finished.

Function
REQ-007 SHALL implement a circular buffer with read pointer rptr, write pointer wptr and occupancy count level; all pointer arithmetic SHALL be modulo DEPTH.
REQ-008 SHALL drive wr_rdy combinationally as (DEPTH-level) >= WR_WIN, independent of wr_vld.
REQ-009 SHALL accept a write when wr_vld and wr_rdy are high at a clock edge: lanes 0..wr_cnt_m1 are stored at wptr..wptr+wr_cnt_m1 and wptr advances by wr_cnt_m1+1.
REQ-010 SHALL ignore a write while wr_rdy is low; no storage or pointer change.
REQ-011 SHALL accept a shift when shift_vld is high and shift_cnt_m1+1 <= level, with level sampled before the same-cycle write; rptr advances by shift_cnt_m1+1.
REQ-012 SHALL reject a shift with shift_cnt_m1+1 > level: rptr is unchanged and shift_err is high for exactly the next cycle.
REQ-013 SHALL update level as level + accepted write lanes - accepted shift lanes when a write and a shift occur in the same cycle.
REQ-014 SHALL, on rd_req at edge t, register rd_data, rd_vld=1 and rd_avail=min(level,RD_WIN), all using the rptr, level and storage contents before edge t; they are visible in cycle t+1 (1-cycle latency).
REQ-015 SHALL set lanes at or above rd_avail to zero; a write or shift in the same cycle as rd_req SHALL NOT affect that response.
REQ-016 SHALL drive rd_vld low and rd_data and rd_avail to zero in any cycle following an edge without rd_req.
REQ-017 SHALL handle window wrap-around seamlessly: writes and reads that span entry DEPTH-1 to entry 0 are contiguous.
REQ-018 SHALL, on flush at an edge, set rptr, wptr and level to 0 and block any same-cycle write or shift; shift_err is not raised; a same-cycle rd_req is answered with rd_avail=0.
REQ-019 SHALL drive level and empty directly from registered state.

Reset
REQ-020 SHALL, when rst_n is low at an edge, set rptr=0, wptr=0, level=0, rd_vld=0, rd_data=0, rd_avail=0 and shift_err=0, overriding flush and all requests.
REQ-021 SHALL leave storage contents unreset.
REQ-022 SHALL show wr_rdy=1 and empty=1 in the cycle after reset.
REQ-023 SHALL, when reset is applied mid-operation, discard all pending data and start clean with pointers at 0.

Verification
REQ-024 Write {0x00,0x61,0x73,0x6d} with wr_cnt_m1=3, then rd_req -> next cycle rd_vld=1, rd_avail=4, lanes 0-3 = 00 61 73 6d, lanes 4-7 = 0.
REQ-025 level=3, shift_cnt_m1=3 -> shift_err=1 for one cycle, level stays 3; then shift_cnt_m1=1 -> level=1, rd_data lane 0 = old lane 2.
REQ-026 Fill to level=DEPTH-3 -> wr_rdy=0, a wr_vld of 4 lanes is ignored; after a 2-lane shift, level=DEPTH-5 and wr_rdy=1.
REQ-027 wptr=DEPTH-2, write 4 lanes {1,2,3,4} -> entries DEPTH-2, DEPTH-1, 0, 1 hold 1 to 4; a read from rptr=DEPTH-2 returns 1,2,3,4 in lanes 0-3.
REQ-028 Simultaneous 4-lane write, 2-lane shift and rd_req at level=5 -> level=7; the response reflects the pre-edge state with rd_avail=5.
REQ-029 Flush asserted together with wr_vld and shift_vld at level=10 -> level=0, empty=1, shift_err=0, and the following read returns rd_avail=0.

Source files
------------

// File: rtl/instr_window_buffer.sv
// instr_window_buffer: circular byte-lane buffer with multi-lane writes,
// windowed reads (1-cycle latency) and variable-length consume.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             drop all contents, pointers back to 0
//   wr_vld/wr_rdy     write handshake; wr_cnt_m1+1 lanes of wr_data stored
//   rd_req            request a window; rd_data/rd_vld/rd_avail next cycle
//   shift_vld         consume shift_cnt_m1+1 lanes; shift_err on underflow
//   level, empty      occupancy (registered)
module instr_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int WR_WIN     = 4,
  parameter int RD_WIN     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_vld,
  input  logic [$clog2(WR_WIN)-1:0]     wr_cnt_m1,
  input  logic [WR_WIN*DATA_WIDTH-1:0]  wr_data,
  output logic                          wr_rdy,
  input  logic                          rd_req,
  output logic [RD_WIN*DATA_WIDTH-1:0]  rd_data,
  output logic                          rd_vld,
  output logic [$clog2(RD_WIN):0]       rd_avail,
  input  logic                          shift_vld,
  input  logic [$clog2(RD_WIN)-1:0]     shift_cnt_m1,
  output logic                          shift_err,
  output logic [ADDR_WIDTH:0]           level,
  output logic                          empty
);

  localparam int WCW = $clog2(WR_WIN);
  localparam int RCW = $clog2(RD_WIN);
  localparam int LW  = ADDR_WIDTH + 1;
  localparam int DW  = DATA_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [LW-1:0]         lvl_t;
  typedef logic [RCW:0]          avl_t;

  localparam lvl_t DEPTH_L  = lvl_t'(DEPTH);
  localparam lvl_t WR_WIN_L = lvl_t'(WR_WIN);
  localparam lvl_t RD_WIN_L = lvl_t'(RD_WIN);
  localparam avl_t RD_WIN_A = avl_t'(RD_WIN);

  logic [DW-1:0] mem [DEPTH];

  ptr_t rptr;
  ptr_t wptr;
  lvl_t level_q;
  logic empty_q;

  lvl_t wr_n;
  lvl_t sh_n;
  lvl_t level_nxt;
  logic wr_go;
  logic sh_ok;
  logic sh_go;
  logic sh_bad;
  avl_t avail;
  logic [RD_WIN*DW-1:0] win;

  assign level  = level_q;
  assign empty  = empty_q;
  assign wr_rdy = (DEPTH_L - level_q) >= WR_WIN_L;

  assign wr_n   = lvl_t'(wr_cnt_m1) + lvl_t'(1);
  assign sh_n   = lvl_t'(shift_cnt_m1) + lvl_t'(1);

  assign wr_go  = wr_vld & wr_rdy & ~flush;
  assign sh_ok  = sh_n <= level_q;
  assign sh_go  = shift_vld & ~flush & sh_ok;
  assign sh_bad = shift_vld & ~flush & ~sh_ok;

  always_comb begin
    level_nxt = level_q;
    if (wr_go) level_nxt = level_nxt + wr_n;
    if (sh_go) level_nxt = level_nxt - sh_n;
  end

  // Window uses pre-edge state; a flush answers with an empty window.
  always_comb begin
    avail = '0;
    if (!flush) begin
      if (level_q >= RD_WIN_L) avail = RD_WIN_A;
      else                     avail = level_q[RCW:0];
    end
  end

  always_comb begin
    win = '0;
    for (int i = 0; i < RD_WIN; i++) begin
      if (avl_t'(i) < avail)
        win[i*DW +: DW] = mem[rptr + ptr_t'(i)];
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_go) begin
      for (int i = 0; i < WR_WIN; i++) begin
        if (WCW'(i) <= wr_cnt_m1)
          mem[wptr + ptr_t'(i)] <= wr_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr      <= '0;
      wptr      <= '0;
      level_q   <= '0;
      empty_q   <= 1'b1;
      rd_vld    <= 1'b0;
      rd_data   <= '0;
      rd_avail  <= '0;
      shift_err <= 1'b0;
    end else begin
      shift_err <= sh_bad;
      rd_vld    <= rd_req;
      rd_data   <= rd_req ? win : '0;
      rd_avail  <= rd_req ? avail : '0;
      if (flush) begin
        rptr    <= '0;
        wptr    <= '0;
        level_q <= '0;
        empty_q <= 1'b1;
      end else begin
        if (wr_go) wptr <= wptr + ptr_t'(wr_n);
        if (sh_go) rptr <= rptr + ptr_t'(sh_n);
        level_q <= level_nxt;
        empty_q <= (level_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_instr_window_buffer.sv
// tb_instr_window_buffer: directed stimulus; read responses checked
// through a scoreboard queue drained by a negedge monitor.
module tb_instr_window_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        wr_vld;
  logic [1:0]  wr_cnt_m1;
  logic [31:0] wr_data;
  logic        wr_rdy;
  logic        rd_req;
  logic [63:0] rd_data;
  logic        rd_vld;
  logic [3:0]  rd_avail;
  logic        shift_vld;
  logic [2:0]  shift_cnt_m1;
  logic        shift_err;
  logic [8:0]  level;
  logic        empty;

  typedef struct packed {
    logic [63:0] d;
    logic [3:0]  a;
  } rsp_t;

  rsp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_on = 1'b0;

  instr_window_buffer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_vld(wr_vld), .wr_cnt_m1(wr_cnt_m1),
    .wr_data(wr_data), .wr_rdy(wr_rdy),
    .rd_req(rd_req), .rd_data(rd_data),
    .rd_vld(rd_vld), .rd_avail(rd_avail),
    .shift_vld(shift_vld), .shift_cnt_m1(shift_cnt_m1),
    .shift_err(shift_err), .level(level), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_vld) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rd_unexpected got=1 want=0");
        end else begin
          rsp_t e;
          e = sbq.pop_front();
          cmp("rd_data", rd_data, e.d);
          cmp("rd_avail", 64'(rd_avail), 64'(e.a));
        end
      end else begin
        cmp("rd_idle", {rd_data[59:0], rd_avail}, 64'h0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    flush     = 1'b0;
    wr_vld    = 1'b0;
    rd_req    = 1'b0;
    shift_vld = 1'b0;
  endtask

  task automatic wr(input logic [1:0] c, input logic [31:0] d);
    wr_vld    = 1'b1;
    wr_cnt_m1 = c;
    wr_data   = d;
  endtask

  task automatic sh(input logic [2:0] c);
    shift_vld    = 1'b1;
    shift_cnt_m1 = c;
  endtask

  task automatic rd(input logic [63:0] d, input logic [3:0] a);
    rsp_t e;
    rd_req = 1'b1;
    e.d = d;
    e.a = a;
    sbq.push_back(e);
  endtask

  initial begin
    logic [31:0] fd;
    rst_n = 1'b0;
    wr_cnt_m1 = '0;
    wr_data = '0;
    shift_cnt_m1 = '0;
    idle();
    tick();
    tick();
    cmp("rst_level", 64'(level), 64'd0);
    cmp("rst_empty", 64'(empty), 64'd1);
    cmp("rst_rd_vld", 64'(rd_vld), 64'd0);
    cmp("rst_shift_err", 64'(shift_err), 64'd0);
    rst_n = 1'b1;
    tick();
    cmp("post_rst_wr_rdy", 64'(wr_rdy), 64'd1);
    cmp("post_rst_empty", 64'(empty), 64'd1);
    mon_on = 1'b1;

    wr(2'd3, 32'h6d736100);
    tick(); idle();
    cmp("lvl_after_wr4", 64'(level), 64'd4);
    rd(64'h6d736100, 4'd4);
    tick(); idle();

    sh(3'd0);
    tick(); idle();
    cmp("lvl_3", 64'(level), 64'd3);
    sh(3'd3);
    tick(); idle();
    cmp("shift_err_hi", 64'(shift_err), 64'd1);
    cmp("lvl_after_rej", 64'(level), 64'd3);
    tick();
    cmp("shift_err_lo", 64'(shift_err), 64'd0);
    sh(3'd1);
    tick(); idle();
    cmp("lvl_1", 64'(level), 64'd1);
    rd(64'h6d, 4'd1);
    tick(); idle();

    wr(2'd3, 32'h14131211);
    tick(); idle();
    cmp("lvl_5", 64'(level), 64'd5);
    wr(2'd3, 32'h24232221);
    sh(3'd1);
    rd(64'h00000014_1312116d, 4'd5);
    tick(); idle();
    cmp("lvl_7", 64'(level), 64'd7);
    rd(64'h00242322_21141312, 4'd7);
    tick(); idle();

    wr(2'd2, 32'h00333231);
    tick(); idle();
    cmp("lvl_10", 64'(level), 64'd10);
    flush = 1'b1;
    wr(2'd3, 32'hcafef00d);
    sh(3'd0);
    rd(64'h0, 4'd0);
    tick(); idle();
    cmp("flush_level", 64'(level), 64'd0);
    cmp("flush_empty", 64'(empty), 64'd1);
    cmp("flush_shift_err", 64'(shift_err), 64'd0);
    rd(64'h0, 4'd0);
    tick(); idle();

    for (int k = 0; k < 63; k++) begin
      for (int i = 0; i < 4; i++) fd[i*8 +: 8] = 8'(k*4 + i);
      wr(2'd3, fd);
      tick();
    end
    idle();
    cmp("lvl_252", 64'(level), 64'd252);
    wr(2'd0, 32'h000000fc);
    tick(); idle();
    cmp("lvl_253", 64'(level), 64'd253);
    cmp("full_wr_rdy", 64'(wr_rdy), 64'd0);
    wr(2'd3, 32'hdeadbeef);
    tick(); idle();
    cmp("ignored_wr_lvl", 64'(level), 64'd253);
    rd(64'h07060504_03020100, 4'd8);
    tick(); idle();
    sh(3'd1);
    tick(); idle();
    cmp("lvl_251", 64'(level), 64'd251);
    cmp("wr_rdy_back", 64'(wr_rdy), 64'd1);

    wr(2'd0, 32'h000000ee);
    tick(); idle();
    wr(2'd3, 32'h04030201);
    tick(); idle();
    cmp("lvl_256", 64'(level), 64'd256);
    cmp("full_empty", 64'(empty), 64'd0);
    cmp("full256_wr_rdy", 64'(wr_rdy), 64'd0);
    for (int j = 0; j < 31; j++) begin
      sh(3'd7);
      tick();
    end
    sh(3'd3);
    tick(); idle();
    cmp("lvl_wrap_4", 64'(level), 64'd4);
    rd(64'h04030201, 4'd4);
    tick(); idle();

    wr(2'd3, 32'h55555555);
    sh(3'd0);
    rd_req = 1'b1;
    rst_n = 1'b0;
    tick(); idle();
    cmp("midrst_level", 64'(level), 64'd0);
    cmp("midrst_empty", 64'(empty), 64'd1);
    cmp("midrst_wr_rdy", 64'(wr_rdy), 64'd1);
    cmp("midrst_shift_err", 64'(shift_err), 64'd0);
    rst_n = 1'b1;
    rd(64'h0, 4'd0);
    tick(); idle();
    tick();
    tick();
    cmp("sb_drain", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
